// File: rtl/lattice_value_buffer.sv
// One-stage valid/ready register for a binomial-lattice value column. Presents each
// node's down (same index) and up (index+1) neighbour, gated by the active-node mask of the tree step.
module lattice_value_buffer #(
  parameter int NODES  = 32,
  parameter int WIDTH  = 64,
  parameter int STEP_W = $clog2(NODES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_start,
  input  logic [NODES*WIDTH-1:0] values_in,
  input  logic [WIDTH-1:0]       top_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NODES*WIDTH-1:0] down_out,
  output logic [NODES*WIDTH-1:0] up_out,
  output logic [NODES-1:0]       active_mask,
  output logic [STEP_W-1:0]      step_out,
  output logic                   last_out,
  output logic                   err_out
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NODES - 1);

  logic [NODES*WIDTH-1:0]     held_r;
  logic [WIDTH-1:0]           held_top_r;
  logic                       out_valid_r;
  logic [STEP_W-1:0]          step_r;
  logic                       err_r;
  logic                       accept_s;
  logic [NODES-1:0]           mask_s;
  logic [(NODES+1)*WIDTH-1:0] ext_s;

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Column capture, handshake state and saturating step / sticky error tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      held_r      <= {(NODES*WIDTH){1'b0}};
      held_top_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      step_r      <= {STEP_W{1'b0}};
      err_r       <= 1'b0;
    end else if (accept_s) begin
      held_r      <= values_in;
      held_top_r  <= top_in;
      out_valid_r <= 1'b1;
      if (in_start) begin
        step_r <= {STEP_W{1'b0}};
        err_r  <= 1'b0;
      end else if (step_r == LAST_STEP) begin
        // A step past the root means the source lost track of the tree
        err_r <= 1'b1;
      end else begin
        step_r <= step_r + STEP_W'(1);
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Node i stays active while i < NODES - step
  always_comb begin
    mask_s = {NODES{1'b0}};
    for (int i = 0; i < NODES; i++) begin
      if ((i + int'(step_r)) < NODES) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // The top boundary value sits just above node NODES-1 so up is a uniform +1 shift
  assign ext_s = {held_top_r, held_r};

  // Masked down/up neighbour presentation
  always_comb begin
    down_out = {(NODES*WIDTH){1'b0}};
    up_out   = {(NODES*WIDTH){1'b0}};
    for (int i = 0; i < NODES; i++) begin
      if (mask_s[i]) begin
        down_out[i*WIDTH +: WIDTH] = ext_s[i*WIDTH +: WIDTH];
        up_out[i*WIDTH +: WIDTH]   = ext_s[(i+1)*WIDTH +: WIDTH];
      end else begin
        down_out[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        up_out[i*WIDTH +: WIDTH]   = {WIDTH{1'b0}};
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign step_out    = step_r;
  assign err_out     = err_r;
  assign active_mask = mask_s;
  assign last_out    = (step_r == LAST_STEP);

endmodule

// File: tb/tb_lattice_value_buffer.sv
// Bench for lattice_value_buffer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural column model.
module tb_lattice_value_buffer;

  localparam int NODES  = 32;
  localparam int WIDTH  = 64;
  localparam int STEP_W = $clog2(NODES);
  localparam int VW     = NODES * WIDTH;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_start;
  logic [VW-1:0]     values_in;
  logic [WIDTH-1:0]  top_in;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     down_out;
  logic [VW-1:0]     up_out;
  logic [NODES-1:0]  active_mask;
  logic [STEP_W-1:0] step_out;
  logic              last_out;
  logic              err_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model of the held column
  logic [WIDTH-1:0] m_col [NODES];
  logic [WIDTH-1:0] m_top;
  bit               m_valid;
  bit               m_err;
  bit               m_fresh;
  int               m_step;
  logic [VW-1:0]    exp_down;
  logic [VW-1:0]    exp_up;
  logic [NODES-1:0] exp_mask;

  lattice_value_buffer #(.NODES(NODES), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_start(in_start), .values_in(values_in), .top_in(top_in),
    .out_valid(out_valid), .out_ready(out_ready), .down_out(down_out),
    .up_out(up_out), .active_mask(active_mask), .step_out(step_out),
    .last_out(last_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    int idx = 0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (act[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]) idx = i;
    end
    chk($sformatf("%s[%0d]", nm, idx), act[idx*WIDTH +: WIDTH], exp[idx*WIDTH +: WIDTH]);
  endtask

  function automatic logic [63:0] dn(input int i);
    return down_out[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [63:0] upn(input int i);
    return up_out[i*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_col();
    for (int i = 0; i < NODES; i++) values_in[i*WIDTH +: WIDTH] = {$urandom(), $urandom()};
    top_in = {$urandom(), $urandom()};
  endtask

  task automatic beat(input logic start);
    in_valid = 1'b1;
    in_start = start;
    rand_col();
    tick();
  endtask

  // Expected outputs derived from the model state
  always_comb begin
    exp_down = {VW{1'b0}};
    exp_up   = {VW{1'b0}};
    exp_mask = {NODES{1'b0}};
    for (int i = 0; i < NODES; i++) begin
      int j;
      j = (i + 1 < NODES) ? i + 1 : 0;
      exp_mask[i] = (i < NODES - m_step);
      if (exp_mask[i]) begin
        exp_down[i*WIDTH +: WIDTH] = m_col[i];
        exp_up[i*WIDTH +: WIDTH]   = (i < NODES - 1) ? m_col[j] : m_top;
      end
    end
  end

  // Model update on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_valid = 1'b0; m_step = 0; m_err = 1'b0; m_fresh = 1'b1; m_top = 64'd0;
        for (int i = 0; i < NODES; i++) m_col[i] = 64'd0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        for (int i = 0; i < NODES; i++) m_col[i] = values_in[i*WIDTH +: WIDTH];
        m_top = top_in; m_valid = 1'b1; m_fresh = 1'b0;
        if (in_start) begin
          m_step = 0; m_err = 1'b0;
        end else begin
          if (m_step == NODES - 1) m_err = 1'b1;
          m_step = (m_step + 1 > NODES - 1) ? NODES - 1 : m_step + 1;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("step_out", 64'(step_out), 64'(m_step));
        chk("err_out", 64'(err_out), 64'(m_err));
        chk("last_out", 64'(last_out), 64'(m_step == NODES - 1));
        chk("active_mask", 64'(active_mask), 64'(exp_mask));
        if (m_valid || m_fresh) begin
          chk_vec("down_out", down_out, exp_down);
          chk_vec("up_out", up_out, exp_up);
        end
      end
    end
  end

  initial begin
    logic [63:0] acc;
    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; out_ready = 1'b0;
    values_in = {VW{1'b0}}; top_in = 64'd0;

    // Reset for two cycles; a beat offered during reset must be dropped
    tick();
    chk_en = 1'b1;
    in_valid = 1'b1; in_start = 1'b1; rand_col();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_step", 64'(step_out), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);
    chk("rst_last", 64'(last_out), 64'd0);
    chk("rst_mask", 64'(active_mask), 64'hFFFF_FFFF);
    acc = 64'd0;
    for (int i = 0; i < NODES; i++) acc = acc | dn(i) | upn(i);
    chk("rst_data_zero", acc, 64'd0);

    // Single beat with node i = i+1
    out_ready = 1'b1; in_valid = 1'b1; in_start = 1'b1; top_in = 64'hAA;
    for (int i = 0; i < NODES; i++) values_in[i*WIDTH +: WIDTH] = 64'(i + 1);
    tick();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_down5", dn(5), 64'd6);
    chk("single_up5", upn(5), 64'd7);
    chk("single_up31", upn(31), 64'hAA);
    chk("single_step", 64'(step_out), 64'd0);
    chk("single_mask", 64'(active_mask), 64'hFFFF_FFFF);

    // Full tree: start then 31 non-start beats
    beat(1'b1);
    chk("tree_step", 64'(step_out), 64'd0);
    for (int k = 1; k < NODES; k++) begin
      beat(1'b0);
      chk("tree_step", 64'(step_out), 64'(k));
      if (k == 30) begin
        acc = 64'd0;
        for (int n = 2; n < NODES; n++) acc = acc | dn(n);
        chk("step30_down_hi_zero", acc, 64'd0);
      end
      if (k == 31) begin
        chk("step31_last", 64'(last_out), 64'd1);
        chk("step31_mask", 64'(active_mask), 64'h1);
      end
    end

    // Saturation and error, then cleared by a new start
    beat(1'b0);
    chk("sat_step", 64'(step_out), 64'd31);
    chk("sat_err", 64'(err_out), 64'd1);
    beat(1'b1);
    chk("restart_err", 64'(err_out), 64'd0);
    chk("restart_step", 64'(step_out), 64'd0);

    // Backpressure with changing input data
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      beat(1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_step_frozen", 64'(step_out), 64'd0);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      beat(1'b0);
      chk("release_step", 64'(step_out), 64'(k));
    end

    // Simultaneous handover for four cycles
    for (int k = 4; k <= 7; k++) begin
      beat(1'b0);
      chk("handover_valid", 64'(out_valid), 64'd1);
      chk("handover_step", 64'(step_out), 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Reset mid-tree at step 10
    beat(1'b1);
    for (int k = 0; k < 10; k++) beat(1'b0);
    chk("pre_rst_step", 64'(step_out), 64'd10);
    reset = 1'b1; in_valid = 1'b1; in_start = 1'b0; rand_col();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_step", 64'(step_out), 64'd0);
    acc = 64'd0;
    for (int i = 0; i < NODES; i++) acc = acc | dn(i) | upn(i);
    chk("midrst_data_zero", acc, 64'd0);
    beat(1'b0);
    chk("post_rst_step", 64'(step_out), 64'd1);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_start  = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_col();
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
